// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one synchronous RAM port between three requesters:
//   0 = CPU data access, 1 = CPU instruction fetch, 2 = video readout.
// One request is latched at a time. The RAM access is sequenced over a fixed
// latency, and the result is returned with a one-cycle, one-hot acknowledge.
//
// Parameters
//   READ_LATENCY      RAM clock edges from address valid to read data valid (1..4)
//
// Build option
//   ARB_ROUND_ROBIN_EN  when defined, grants rotate starting after the last
//                       granted requester; otherwise fixed priority 0 > 1 > 2.
//
// Ports
//   wire_clock        system clock, rising edge
//   wire_reset        synchronous active-high reset
//   req[2:0]          per-requester request
//   we[2:0]           per-requester write enable (1 = write)
//   addr0..addr2      per-requester address
//   wdata0..wdata2    per-requester write data
//   ack[2:0]          one-hot completion pulse, one cycle
//   rdata             read data, valid while the matching ack bit is high
//   busy              high whenever the arbiter is not idle
//   bus_RAM_ADDRESS   RAM address (holds its last value when idle)
//   bus_RAM_DATA_IN   RAM write data (holds its last value when idle)
//   bus_RAM_DATA_OUT  RAM read data
//   wire_RW           1 = write strobe, 0 = read
//
// Timing (E0 = edge at which IDLE grants a request)
//   read : ack is high in the cycle after E0+READ_LATENCY+1
//   write: wire_RW is high for the cycle after E0; ack is high in the cycle
//          after E0+2

module ram_port_arbiter #(
   parameter int READ_LATENCY = 1
) (
   input  logic        wire_clock,
   input  logic        wire_reset,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [15:0] addr2,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   input  logic [15:0] wdata2,
   output logic [2:0]  ack,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [15:0] bus_RAM_ADDRESS,
   output logic [15:0] bus_RAM_DATA_IN,
   input  logic [15:0] bus_RAM_DATA_OUT,
   output logic        wire_RW
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   // Final value of the wait counter for a read.
   localparam logic [1:0] LAST_READ_CNT = 2'(READ_LATENCY - 1);

   state_t      state_reg, state_next;
   logic [1:0]  winner_reg, winner_next;
   logic        write_reg, write_next;
   logic        sample_reg, sample_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic        rw_reg, rw_next;
   logic [15:0] rdata_reg, rdata_next;
   logic [15:0] addr_reg, addr_next;
   logic [15:0] wdata_reg, wdata_next;

   logic        grant_valid;
   logic [1:0]  grant_idx;

   // Requester inputs gathered into index-able form. Slot 3 is never granted.
   logic [15:0] addr_sel  [0:3];
   logic [15:0] wdata_sel [0:3];
   logic [3:0]  we_ext;

   assign addr_sel[0]  = addr0;
   assign addr_sel[1]  = addr1;
   assign addr_sel[2]  = addr2;
   assign addr_sel[3]  = '0;
   assign wdata_sel[0] = wdata0;
   assign wdata_sel[1] = wdata1;
   assign wdata_sel[2] = wdata2;
   assign wdata_sel[3] = '0;
   assign we_ext       = {1'b0, we};

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
   // Index of the last granted requester; the search starts one past it.
   logic [1:0] ptr_reg, ptr_next;

   always_comb begin
      grant_valid = |req;
      grant_idx   = 2'd0;
      case (ptr_reg)
         2'd0: begin
            if (req[1])      grant_idx = 2'd1;
            else if (req[2]) grant_idx = 2'd2;
            else             grant_idx = 2'd0;
         end
         2'd1: begin
            if (req[2])      grant_idx = 2'd2;
            else if (req[0]) grant_idx = 2'd0;
            else             grant_idx = 2'd1;
         end
         default: begin
            if (req[0])      grant_idx = 2'd0;
            else if (req[1]) grant_idx = 2'd1;
            else             grant_idx = 2'd2;
         end
      endcase
   end
`else
   always_comb begin
      grant_valid = |req;
      if (req[0])      grant_idx = 2'd0;
      else if (req[1]) grant_idx = 2'd1;
      else             grant_idx = 2'd2;
   end
`endif

   // ------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      winner_next = winner_reg;
      write_next  = write_reg;
      sample_next = sample_reg;
      cnt_next    = cnt_reg;
      rw_next     = rw_reg;
      rdata_next  = rdata_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_next    = ptr_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               winner_next = grant_idx;
               addr_next   = addr_sel[grant_idx];
               wdata_next  = wdata_sel[grant_idx];
               write_next  = we_ext[grant_idx];
               rw_next     = we_ext[grant_idx];
               cnt_next    = 2'd0;
               sample_next = 1'b0;
               state_next  = ST_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
               ptr_next    = grant_idx;
`endif
            end
         end

         ST_ACCESS: begin
            // The access has two phases. First the counted phase holds the
            // address for the RAM latency, or for one write strobe. Then one
            // sample cycle follows, in which the RAM's registered output is
            // valid and gets captured.
            if (sample_reg) begin
               if (!write_reg) begin
                  rdata_next = bus_RAM_DATA_OUT;
               end
               sample_next = 1'b0;
               state_next  = ST_ACK;
            end else if (write_reg || (cnt_reg == LAST_READ_CNT)) begin
               sample_next = 1'b1;
               rw_next     = 1'b0;
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end

         ST_ACK: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge wire_clock) begin
      if (wire_reset) begin
         state_reg  <= ST_IDLE;
         winner_reg <= 2'd0;
         write_reg  <= 1'b0;
         sample_reg <= 1'b0;
         cnt_reg    <= 2'd0;
         rw_reg     <= 1'b0;
         rdata_reg  <= 16'h0000;
         addr_reg   <= 16'h0000;
         wdata_reg  <= 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_reg    <= 2'd2;
`endif
      end else begin
         state_reg  <= state_next;
         winner_reg <= winner_next;
         write_reg  <= write_next;
         sample_reg <= sample_next;
         cnt_reg    <= cnt_next;
         rw_reg     <= rw_next;
         rdata_reg  <= rdata_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_reg    <= ptr_next;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // ack is decoded from registered state only, so it lasts exactly the ACK cycle.
   for (genvar gi = 0; gi < 3; gi++) begin : g_ack
      assign ack[gi] = (state_reg == ST_ACK) && (winner_reg == 2'(gi));
   end

   assign busy            = (state_reg != ST_IDLE);
   assign rdata           = rdata_reg;
   assign bus_RAM_ADDRESS = addr_reg;
   assign bus_RAM_DATA_IN = wdata_reg;
   assign wire_RW         = rw_reg;

endmodule
